// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - sums TERMS multiplier products into one handshaked result (optional MULT_ACCUMULATOR_SATURATE_EN)
module mult_accumulator #(
    parameter int SIZE      = 8,
    parameter int ACC_WIDTH = 24,
    parameter int TERMS     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*SIZE-1:0]     prod,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic                  clear,
    output logic [ACC_WIDTH-1:0]  res,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  overflow,
    output logic                  busy
);

    localparam int PW = 2 * SIZE;
    localparam int CW = $clog2(TERMS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    generate
        if (ACC_WIDTH < 2 * SIZE) begin : g_bad_width
            $error("mult_accumulator: ACC_WIDTH must be >= 2*SIZE");
        end
        if (TERMS < 1) begin : g_bad_terms
            $error("mult_accumulator: TERMS must be >= 1");
        end
    endgenerate

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 ovf_q;

    logic                 accept;
    logic                 last_term;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_next;

    // Combinational handshake, adder and wrap/saturate selection
    always_comb begin
        prod_ready = !clear && (state != S_DONE);
        accept     = prod_valid && prod_ready;
        last_term  = (cnt == CW'(TERMS - 1));
        sum_ext    = {1'b0, acc} + {{(ACC_WIDTH + 1 - PW){1'b0}}, prod};
        carry      = sum_ext[ACC_WIDTH];
`ifdef MULT_ACCUMULATOR_SATURATE_EN
        // Once pinned at all ones, any further nonzero term carries again, so it stays pinned
        acc_next   = carry ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
        acc_next   = sum_ext[ACC_WIDTH-1:0];
`endif
    end

    // Accumulation state machine; clear outranks everything except reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc   <= {{(ACC_WIDTH - PW){1'b0}}, prod};
                        cnt   <= CW'(1);
                        ovf_q <= 1'b0;
                        state <= (TERMS == 1) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CW'(1);
                        if (carry) begin
                            ovf_q <= 1'b1;
                        end
                        if (last_term) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // acc is left alone so res keeps its value after the handshake
                    if (res_ready) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign res       = acc;
    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - self-checking bench for mult_accumulator (default and 16-bit/2-term instances)
module tb_mult_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (SIZE 8, ACC_WIDTH 24, TERMS 4)
    logic [15:0] a_prod = '0;
    logic        a_valid = 1'b0, a_clear = 1'b0, a_rready = 1'b0;
    logic        a_pready, a_rvalid, a_ovf, a_busy;
    logic [23:0] a_res;

    // Instance B: ACC_WIDTH 16, TERMS 2
    logic [15:0] b_prod = '0;
    logic        b_valid = 1'b0, b_clear = 1'b0, b_rready = 1'b0;
    logic        b_pready, b_rvalid, b_ovf, b_busy;
    logic [15:0] b_res;

    mult_accumulator u_a (
        .clk(clk), .rst_n(rst_n), .prod(a_prod), .prod_valid(a_valid), .prod_ready(a_pready),
        .clear(a_clear), .res(a_res), .res_valid(a_rvalid), .res_ready(a_rready),
        .overflow(a_ovf), .busy(a_busy)
    );

    mult_accumulator #(.SIZE(8), .ACC_WIDTH(16), .TERMS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .prod(b_prod), .prod_valid(b_valid), .prod_ready(b_pready),
        .clear(b_clear), .res(b_res), .res_valid(b_rvalid), .res_ready(b_rready),
        .overflow(b_ovf), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of a true (unbounded) sum as seen in a W-bit accumulator
    function automatic longint fold(input longint s, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
`ifdef MULT_ACCUMULATOR_SATURATE_EN
        return (s > m) ? m : s;
`else
        return s & m;
`endif
    endfunction

    function automatic longint nsum(input int n, input longint s, input logic [15:0] p);
        return ((n == 0) ? 64'd0 : s) + longint'(p);
    endfunction

    // Reference: count of terms in the current group, exact running sum, held flag
    int     ma_n = 0, mb_n = 0;
    longint ma_sum = 0, mb_sum = 0, ma_res = 0, mb_res = 0;
    bit     ma_held = 1'b0, mb_held = 1'b0;

    // Reference model for instance A
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || a_clear) begin
            ma_n <= 0; ma_sum <= 0; ma_res <= 0; ma_held <= 1'b0;
        end else if (ma_held) begin
            if (a_rready) ma_held <= 1'b0;
        end else if (a_valid) begin
            ma_sum  <= nsum(ma_n, ma_sum, a_prod);
            ma_res  <= fold(nsum(ma_n, ma_sum, a_prod), 24);
            ma_n    <= (ma_n + 1 == 4) ? 0 : ma_n + 1;
            ma_held <= (ma_n + 1 == 4);
        end
    end

    // Reference model for instance B
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || b_clear) begin
            mb_n <= 0; mb_sum <= 0; mb_res <= 0; mb_held <= 1'b0;
        end else if (mb_held) begin
            if (b_rready) mb_held <= 1'b0;
        end else if (b_valid) begin
            mb_sum  <= nsum(mb_n, mb_sum, b_prod);
            mb_res  <= fold(nsum(mb_n, mb_sum, b_prod), 16);
            mb_n    <= (mb_n + 1 == 2) ? 0 : mb_n + 1;
            mb_held <= (mb_n + 1 == 2);
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("A prod_ready", a_pready, !a_clear && !ma_held);
            chk("A res_valid", a_rvalid, ma_held);
            chk("A busy", a_busy, ma_held || (ma_n != 0));
            chk("A res", a_res, ma_res[23:0]);
            chk("A overflow", a_ovf, ma_sum > 64'hFFFFFF);
            chk("B prod_ready", b_pready, !b_clear && !mb_held);
            chk("B res_valid", b_rvalid, mb_held);
            chk("B busy", b_busy, mb_held || (mb_n != 0));
            chk("B res", b_res, mb_res[15:0]);
            chk("B overflow", b_ovf, mb_sum > 64'hFFFF);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_term(input logic [15:0] p);
        a_prod = p; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
    endtask

    task automatic b_term(input logic [15:0] p);
        b_prod = p; b_valid = 1'b1;
        cyc();
        b_valid = 1'b0;
    endtask

    logic [15:0] basic_v [4] = '{16'h0009, 16'h0006, 16'h0000, 16'h0019};
    int          gaps    [3] = '{1, 2, 3};
    logic [15:0] b_exp;

    initial begin
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        #1;
        chk("reset res", a_res, 24'h0);
        chk("reset res_valid", a_rvalid, 1'b0);
        chk("reset busy", a_busy, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Asynchronous reset in the middle of a group
        a_term(16'h0009);
        a_term(16'h0006);
        chk("partial res", a_res, 24'h00000F);
        #2 rst_n = 1'b0;
        #1;
        chk("async res", a_res, 24'h0);
        chk("async res_valid", a_rvalid, 1'b0);
        chk("async busy", a_busy, 1'b0);
        chk("async overflow", a_ovf, 1'b0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post-reset prod_ready", a_pready, 1'b1);
        cyc();

        // Back-to-back terms
        for (int i = 0; i < 4; i++) begin
            a_term(basic_v[i]);
            if (i == 2) chk("basic not yet valid", a_rvalid, 1'b0);
        end
        chk("basic res_valid", a_rvalid, 1'b1);
        chk("basic res", a_res, 24'h000028);
        chk("basic overflow", a_ovf, 1'b0);

        // Consumer stalls while the producer keeps offering
        a_prod = 16'h00FF; a_valid = 1'b1; a_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp prod_ready", a_pready, 1'b0);
            chk("bp res", a_res, 24'h000028);
            cyc();
        end
        a_rready = 1'b1;
        cyc();
        a_rready = 1'b0; a_valid = 1'b0;
        chk("bp after res_valid", a_rvalid, 1'b0);
        chk("bp after busy", a_busy, 1'b0);
        cyc();

        // Bubbles between terms
        for (int i = 0; i < 4; i++) begin
            a_term(basic_v[i]);
            if (i < 3) repeat (gaps[i]) cyc();
        end
        chk("bubble res_valid", a_rvalid, 1'b1);
        chk("bubble res", a_res, 24'h000028);
        a_rready = 1'b1;
        cyc();
        a_rready = 1'b0;

        // Clear aborts a partial group and blocks the term offered with it
        a_term(16'h0001);
        a_term(16'h0001);
        a_clear = 1'b1; a_valid = 1'b1; a_prod = 16'h0001;
        #1;
        chk("clear prod_ready", a_pready, 1'b0);
        cyc();
        a_clear = 1'b0; a_valid = 1'b0;
        chk("clear busy", a_busy, 1'b0);
        chk("clear res", a_res, 24'h0);
        for (int i = 0; i < 4; i++) a_term(16'h0001);
        chk("after clear res", a_res, 24'h000004);
        chk("after clear res_valid", a_rvalid, 1'b1);

        // Clear in DONE with res_ready high discards the result
        a_clear = 1'b1; a_rready = 1'b1;
        cyc();
        a_clear = 1'b0; a_rready = 1'b0;
        chk("clear done res_valid", a_rvalid, 1'b0);
        chk("clear done res", a_res, 24'h0);
        cyc();

        // Overflow on the narrow instance
`ifdef MULT_ACCUMULATOR_SATURATE_EN
        b_exp = 16'hFFFF;
`else
        b_exp = 16'h0001;
`endif
        b_term(16'hFFFF);
        b_term(16'h0002);
        chk("ovf res_valid", b_rvalid, 1'b1);
        chk("ovf res", b_res, b_exp);
        chk("ovf flag", b_ovf, 1'b1);
        b_rready = 1'b1;
        cyc();
        b_rready = 1'b0;
        chk("ovf held after handshake", b_ovf, 1'b1);
        b_term(16'h0001);
        chk("ovf cleared by new group", b_ovf, 1'b0);
        b_term(16'h0001);
        chk("small res", b_res, 16'h0002);
        chk("small overflow", b_ovf, 1'b0);
        b_rready = 1'b1;
        cyc();
        b_rready = 1'b0;
        repeat (3) cyc();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
